// File: rtl/fpp_param_alu.sv
// Parametrised multi-cycle floating-point ALU (sign/exponent/mantissa, no Inf/NaN, truncating).
// ADD/SUB/MUL walk ALIGN->CALC->NORM->DONE; every other opcode resolves in one cycle.
module fpp_param_alu #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         st,
    input  logic [3:0]   ALUFunction,
    input  logic [W-1:0] DATA,
    input  logic [W-1:0] REGA,
    input  logic [W-1:0] REGB,
    output logic [W-1:0] REGOUT,
    output logic         en,
    output logic         flag_io,
    output logic         busy,
    output logic         ovf,
    output logic         unf,
    output logic         zero,
    output logic         ill
);
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX = (1 << EXP_W) - 1;
    localparam int MW1  = MAN_W + 1;
    localparam int PW   = 2 * MW1;
    localparam int EW2  = EXP_W + 2;
    localparam logic signed [EW2-1:0] EMAX_S = EW2'(EMAX);
    localparam logic signed [EW2-1:0] ONE_S  = EW2'(1);
    localparam logic signed [EW2-1:0] BIAS_S = EW2'(BIAS);

    localparam logic [3:0] OP_LOAD  = 4'd0;
    localparam logic [3:0] OP_MOV   = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_NEG   = 4'd3;
    localparam logic [3:0] OP_STORE = 4'd4;
    localparam logic [3:0] OP_MUL   = 4'd6;
    localparam logic [3:0] OP_MAX   = 4'd7;
    localparam logic [3:0] OP_SUB   = 4'd8;
    localparam logic [3:0] OP_CLR   = 4'd9;
    localparam logic [3:0] OP_MIN   = 4'd10;
    localparam logic [3:0] OP_ABS   = 4'd11;

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_CALC, S_NORM, S_DONE} state_t;

    state_t r_state, w_next;

    logic [3:0]            r_op;
    logic [W-1:0]          r_a, r_b, r_result;
    logic                  r_sign, r_effSub, r_mulZero;
    logic signed [EW2-1:0] r_exp;
    logic [MW1-1:0]        r_mBig, r_mSmall;
    logic [PW-1:0]         r_sum;
    logic                  r_ovf, r_unf, r_zero, r_ill;

    logic                  w_isArith;
    logic [W-1:0]          w_quickRes;
    logic                  w_quickIll, w_quickZero;
    logic signed [W:0]     w_keyA, w_keyB;

    logic [EXP_W-1:0]      w_ea, w_eb, w_eBig, w_eSmall, w_d;
    logic [MW1-1:0]        w_ma, w_mb, w_mBig, w_mSmallRaw;
    logic                  w_sa, w_sb, w_aBig;
    logic signed [EW2-1:0] w_mulExp;

    int                    w_lead;
    logic [MW1-1:0]        w_shifted;
    logic signed [EW2-1:0] w_nExp;
    logic [MAN_W-1:0]      w_nMan;
    logic                  w_nZero;
    logic [W-1:0]          w_normRes;
    logic                  w_normOvf, w_normUnf, w_normZero;

    // Ordered key for sign-magnitude compare; any exponent-0 value maps to 0 so +0 == -0.
    function automatic logic signed [W:0] sortKey(input logic [W-1:0] x);
        logic signed [W:0] mag;
        mag = $signed({2'b00, x[W-2:0]});
        if (x[W-2:MAN_W] == '0)
            return '0;
        return x[W-1] ? -mag : mag;
    endfunction

    assign w_isArith = (ALUFunction == OP_ADD) || (ALUFunction == OP_SUB) || (ALUFunction == OP_MUL);
    assign w_keyA    = sortKey(REGA);
    assign w_keyB    = sortKey(REGB);

    always_comb begin
        w_quickRes = '0;
        w_quickIll = 1'b0;
        case (ALUFunction)
            OP_LOAD:                 w_quickRes = DATA;
            OP_MOV, OP_STORE:        w_quickRes = REGA;
            OP_NEG:                  w_quickRes = {~REGA[W-1], REGA[W-2:0]};
            OP_ABS:                  w_quickRes = {1'b0, REGA[W-2:0]};
            OP_CLR:                  w_quickRes = '0;
            OP_MAX:                  w_quickRes = (w_keyA >= w_keyB) ? REGA : REGB;
            OP_MIN:                  w_quickRes = (w_keyA <= w_keyB) ? REGA : REGB;
            OP_ADD, OP_SUB, OP_MUL:  w_quickRes = '0;
            default:                 w_quickIll = 1'b1;
        endcase
    end

    assign w_quickZero = (w_quickRes[W-2:MAN_W] == '0);

    // Alignment works on the captured operands; SUB is an ADD with B's sign flipped.
    assign w_ea        = r_a[W-2:MAN_W];
    assign w_eb        = r_b[W-2:MAN_W];
    assign w_ma        = (w_ea == '0) ? '0 : {1'b1, r_a[MAN_W-1:0]};
    assign w_mb        = (w_eb == '0) ? '0 : {1'b1, r_b[MAN_W-1:0]};
    assign w_sa        = r_a[W-1];
    assign w_sb        = r_b[W-1] ^ (r_op == OP_SUB);
    assign w_aBig      = {w_ea, w_ma} >= {w_eb, w_mb};
    assign w_eBig      = w_aBig ? w_ea : w_eb;
    assign w_eSmall    = w_aBig ? w_eb : w_ea;
    assign w_mBig      = w_aBig ? w_ma : w_mb;
    assign w_mSmallRaw = w_aBig ? w_mb : w_ma;
    assign w_d         = w_eBig - w_eSmall;
    assign w_mulExp    = $signed(EW2'(w_ea)) + $signed(EW2'(w_eb)) - BIAS_S;

    always_comb begin
        w_lead = 0;
        for (int i = 0; i < MW1; i++)
            if (r_sum[i])
                w_lead = i;
        w_shifted = r_sum[MAN_W:0] << (MAN_W - w_lead);
        w_nExp    = r_exp;
        w_nMan    = '0;
        w_nZero   = 1'b0;
        if (r_op == OP_MUL) begin
            if (r_mulZero)
                w_nZero = 1'b1;
            else if (r_sum[PW-1]) begin
                w_nExp = r_exp + ONE_S;
                w_nMan = r_sum[PW-2 -: MAN_W];
            end else
                w_nMan = r_sum[PW-3 -: MAN_W];
        end else if (r_sum[MW1:0] == '0)
            w_nZero = 1'b1;
        else if (r_sum[MW1]) begin
            w_nExp = r_exp + ONE_S;
            w_nMan = r_sum[MAN_W:1];
        end else begin
            w_nExp = r_exp - EW2'(MAN_W - w_lead);
            w_nMan = w_shifted[MAN_W-1:0];
        end

        w_normRes = '0;
        w_normOvf = 1'b0;
        w_normUnf = 1'b0;
        if (!w_nZero) begin
            if (w_nExp > EMAX_S) begin
                w_normRes = {r_sign, {(W-1){1'b1}}};
                w_normOvf = 1'b1;
            end else if (w_nExp < ONE_S)
                w_normUnf = 1'b1;
            else
                w_normRes = {r_sign, w_nExp[EXP_W-1:0], w_nMan};
        end
    end

    assign w_normZero = (w_normRes[W-2:MAN_W] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next state plus the Moore handshake outputs decoded from state.
    always_comb begin
        w_next  = r_state;
        en      = 1'b0;
        flag_io = 1'b0;
        busy    = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (st)
                    w_next = w_isArith ? S_ALIGN : S_DONE;
            end
            S_ALIGN: w_next = S_CALC;
            S_CALC:  w_next = S_NORM;
            S_NORM:  w_next = S_DONE;
            S_DONE: begin
                en      = 1'b1;
                flag_io = (r_op == OP_STORE);
                w_next  = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_result  <= '0;
            r_sign    <= 1'b0;
            r_effSub  <= 1'b0;
            r_mulZero <= 1'b0;
            r_exp     <= '0;
            r_mBig    <= '0;
            r_mSmall  <= '0;
            r_sum     <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_zero    <= 1'b0;
            r_ill     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (st) begin
                    r_op  <= ALUFunction;
                    r_a   <= REGA;
                    r_b   <= REGB;
                    r_ovf <= 1'b0;
                    r_unf <= 1'b0;
                    if (w_isArith) begin
                        r_zero <= 1'b0;
                        r_ill  <= 1'b0;
                    end else begin
                        r_result <= w_quickRes;
                        r_zero   <= w_quickZero;
                        r_ill    <= w_quickIll;
                    end
                end
                S_ALIGN: begin
                    if (r_op == OP_MUL) begin
                        r_sign    <= w_sa ^ w_sb;
                        r_exp     <= w_mulExp;
                        r_mulZero <= (w_ea == '0) || (w_eb == '0);
                        r_mBig    <= w_ma;
                        r_mSmall  <= w_mb;
                        r_effSub  <= 1'b0;
                    end else begin
                        r_sign    <= w_aBig ? w_sa : w_sb;
                        r_exp     <= $signed(EW2'(w_eBig));
                        r_mulZero <= 1'b0;
                        r_mBig    <= w_mBig;
                        r_mSmall  <= w_mSmallRaw >> w_d;
                        r_effSub  <= w_sa ^ w_sb;
                    end
                end
                S_CALC: begin
                    if (r_op == OP_MUL)
                        r_sum <= PW'(r_mBig) * PW'(r_mSmall);
                    else if (r_effSub)
                        r_sum <= PW'(r_mBig) - PW'(r_mSmall);
                    else
                        r_sum <= PW'(r_mBig) + PW'(r_mSmall);
                end
                S_NORM: begin
                    r_result <= w_normRes;
                    r_ovf    <= w_normOvf;
                    r_unf    <= w_normUnf;
                    r_zero   <= w_normZero;
                    r_ill    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign REGOUT = r_result;
    assign ovf    = r_ovf;
    assign unf    = r_unf;
    assign zero   = r_zero;
    assign ill    = r_ill;
endmodule

// File: tb/tb_fpp_param_alu.sv
// Bench for fpp_param_alu: vector table driven through a scoreboard, plus handshake
// corner sequences and a single-precision instance.
module tb_fpp_param_alu;
    logic        clk = 1'b0;
    logic        rst;
    logic        st;
    logic [3:0]  ALUFunction;
    logic [15:0] DATA, REGA, REGB, REGOUT;
    logic        en, flag_io, busy, ovf, unf, zero, ill;

    logic        st32;
    logic [3:0]  op32;
    logic [31:0] data32, a32, b32, out32;
    logic        en32, fio32, busy32, ovf32, unf32, zero32, ill32;

    always #5 clk = ~clk;

    fpp_param_alu dut (
        .clk(clk), .rst(rst), .st(st), .ALUFunction(ALUFunction),
        .DATA(DATA), .REGA(REGA), .REGB(REGB), .REGOUT(REGOUT),
        .en(en), .flag_io(flag_io), .busy(busy),
        .ovf(ovf), .unf(unf), .zero(zero), .ill(ill)
    );

    fpp_param_alu #(.EXP_W(8), .MAN_W(23)) dut32 (
        .clk(clk), .rst(rst), .st(st32), .ALUFunction(op32),
        .DATA(data32), .REGA(a32), .REGB(b32), .REGOUT(out32),
        .en(en32), .flag_io(fio32), .busy(busy32),
        .ovf(ovf32), .unf(unf32), .zero(zero32), .ill(ill32)
    );

    // flags packs {ovf, unf, zero, ill, flag_io} as seen during the en cycle.
    typedef struct {
        logic [3:0]  op;
        logic [15:0] data;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [4:0]  flags;
        int          lat;
        int          start;
        int          idx;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    vec_t monExp;
    int   tests = 0;
    int   fails = 0;
    int   cycleCount = 0;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic [3:0] op, input logic [15:0] data, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] res, input logic [4:0] flags,
                          input int lat);
        vec_t v;
        v.op = op; v.data = data; v.a = a; v.b = b; v.res = res;
        v.flags = flags; v.lat = lat; v.start = 0; v.idx = vecs.size();
        vecs.push_back(v);
    endtask

    // Every en pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (en) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_en: en=1 with nothing pending, REGOUT=%h", REGOUT);
            end else begin
                monExp = sb.pop_front();
                checkOutput($sformatf("v%0d_result", monExp.idx), {16'h0, REGOUT}, {16'h0, monExp.res});
                checkOutput($sformatf("v%0d_flags", monExp.idx), {27'h0, ovf, unf, zero, ill, flag_io},
                            {27'h0, monExp.flags});
                checkOutput($sformatf("v%0d_latency", monExp.idx), cycleCount - monExp.start, monExp.lat);
            end
        end
    end

    // Drive one operation, scramble the inputs after capture, then wait for IDLE.
    task automatic applyStimulus(input vec_t v);
        vec_t e;
        int   busyCnt;
        @(negedge clk);
        ALUFunction = v.op; DATA = v.data; REGA = v.a; REGB = v.b; st = 1'b1;
        e = v;
        e.start = cycleCount;
        sb.push_back(e);
        @(negedge clk);
        st = 1'b0;
        ALUFunction = 4'($urandom);
        DATA = 16'($urandom);
        REGA = 16'($urandom);
        REGB = 16'($urandom);
        busyCnt = 0;
        for (int k = 0; k < 20 && busy; k++) begin
            busyCnt++;
            @(negedge clk);
        end
        checkOutput($sformatf("v%0d_busy_cycles", v.idx), busyCnt, v.lat);
        checkOutput($sformatf("v%0d_en_low_after", v.idx), {31'h0, en}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, %0d tests run", tests);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t e;
        int   s, lat, got;
        logic [31:0] res32;

        rst = 1'b1; st = 1'b0; ALUFunction = '0; DATA = '0; REGA = '0; REGB = '0;
        st32 = 1'b0; op32 = '0; data32 = '0; a32 = '0; b32 = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", {9'h0, REGOUT, en, flag_io, busy, ovf, unf, zero, ill}, 32'h0);
        checkOutput("reset_regout32", out32, 32'h0);
        checkOutput("reset_status32", {25'h0, en32, fio32, busy32, ovf32, unf32, zero32, ill32}, 32'h0);
        rst = 1'b0;

        addVec(4'd2,  16'h0, 16'h3C00, 16'h4000, 16'h4200, 5'b00000, 4);
        addVec(4'd2,  16'h0, 16'h3C00, 16'h3C00, 16'h4000, 5'b00000, 4);
        addVec(4'd2,  16'h0, 16'h3C00, 16'hBA00, 16'h3400, 5'b00000, 4);
        addVec(4'd2,  16'h0, 16'h7C00, 16'h7C00, 16'h7FFF, 5'b10000, 4);
        addVec(4'd2,  16'h0, 16'h0000, 16'hC200, 16'hC200, 5'b00000, 4);
        addVec(4'd2,  16'h0, 16'h6400, 16'h3C00, 16'h6401, 5'b00000, 4);
        addVec(4'd2,  16'h0, 16'h6800, 16'h3C00, 16'h6800, 5'b00000, 4);
        addVec(4'd8,  16'h0, 16'h3C00, 16'h3C00, 16'h0000, 5'b00100, 4);
        addVec(4'd8,  16'h0, 16'h4200, 16'h3C00, 16'h4000, 5'b00000, 4);
        addVec(4'd8,  16'h0, 16'h0400, 16'h0600, 16'h0000, 5'b01100, 4);
        addVec(4'd6,  16'h0, 16'h4000, 16'h3E00, 16'h4200, 5'b00000, 4);
        addVec(4'd6,  16'h0, 16'h7800, 16'h7800, 16'h7FFF, 5'b10000, 4);
        addVec(4'd6,  16'h0, 16'h0400, 16'h0400, 16'h0000, 5'b01100, 4);
        addVec(4'd6,  16'h0, 16'h0000, 16'h4000, 16'h0000, 5'b00100, 4);
        addVec(4'd6,  16'h0, 16'hC000, 16'h3E00, 16'hC200, 5'b00000, 4);
        addVec(4'd7,  16'h0, 16'hC000, 16'h3C00, 16'h3C00, 5'b00000, 1);
        addVec(4'd10, 16'h0, 16'hC000, 16'h3C00, 16'hC000, 5'b00000, 1);
        addVec(4'd11, 16'h0, 16'hC000, 16'h3C00, 16'h4000, 5'b00000, 1);
        addVec(4'd4,  16'h0, 16'hC000, 16'h3C00, 16'hC000, 5'b00001, 1);
        addVec(4'd5,  16'h0, 16'hC000, 16'h3C00, 16'h0000, 5'b00110, 1);
        addVec(4'd15, 16'h0, 16'hC000, 16'h3C00, 16'h0000, 5'b00110, 1);
        addVec(4'd0,  16'h1234, 16'hC000, 16'h3C00, 16'h1234, 5'b00000, 1);
        addVec(4'd3,  16'h0, 16'hC000, 16'h3C00, 16'h4000, 5'b00000, 1);
        addVec(4'd9,  16'h0, 16'hC000, 16'h3C00, 16'h0000, 5'b00100, 1);
        addVec(4'd7,  16'h0, 16'h8000, 16'h0000, 16'h8000, 5'b00100, 1);
        addVec(4'd10, 16'h0, 16'h0000, 16'h8000, 16'h0000, 5'b00100, 1);
        addVec(4'd7,  16'h0, 16'hC000, 16'hBC00, 16'hBC00, 5'b00000, 1);
        addVec(4'd1,  16'h0, 16'h5555, 16'h0000, 16'h5555, 5'b00000, 1);

        foreach (vecs[i])
            applyStimulus(vecs[i]);

        // A start pulse while the ADD is in ALIGN must be dropped.
        @(negedge clk);
        ALUFunction = 4'd2; REGA = 16'h3C00; REGB = 16'h4000; st = 1'b1;
        e = vecs[0];
        e.idx = 100;
        e.start = cycleCount;
        sb.push_back(e);
        @(negedge clk);
        ALUFunction = 4'd9; st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        for (int k = 0; k < 20 && busy; k++)
            @(negedge clk);
        repeat (4) @(negedge clk);
        checkOutput("align_st_ignored_idle", {31'h0, busy}, 32'h0);
        checkOutput("align_st_result_kept", {16'h0, REGOUT}, 32'h4200);

        // Reset asserted in CALC clears everything at once and suppresses en.
        @(negedge clk);
        ALUFunction = 4'd2; REGA = 16'h3C00; REGB = 16'h3C00; st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        @(negedge clk);
        checkOutput("calc_busy_before_rst", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_outputs", {9'h0, REGOUT, en, flag_io, busy, ovf, unf, zero, ill}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        e = vecs[8];
        e.idx = 200;
        applyStimulus(e);

        // Single-precision instance: 1.0 + 2.0.
        @(negedge clk);
        op32 = 4'd2; a32 = 32'h3F800000; b32 = 32'h40000000; st32 = 1'b1;
        s = cycleCount;
        @(negedge clk);
        st32 = 1'b0; a32 = $urandom; b32 = $urandom;
        got = 0; lat = -1; res32 = '0;
        for (int k = 0; k < 20 && got == 0; k++) begin
            if (en32) begin
                got = 1;
                lat = cycleCount - s;
                res32 = out32;
            end else
                @(negedge clk);
        end
        checkOutput("fp32_add_result", res32, 32'h40400000);
        checkOutput("fp32_add_latency", lat, 4);

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fpp_param_alu.md
# fpp_param_alu

Parametrised multi-cycle floating-point ALU, successor to the fixed 16-bit FPP ALU. Operand widths follow `EXP_W`/`MAN_W`, so one RTL serves the half- and single-precision datapaths. Compared with the 16-bit ALU it adds:
- operand capture at start, so inputs may change once an operation begins;
- SUB, MIN and ABS opcodes;
- overflow saturation and status flags;
- a `busy` output.

It sits between the register file and the FPP controller and keeps the `st`/`en` handshake.

## Interface
- `EXP_W`, default 5: exponent field width.
- `MAN_W`, default 10: stored mantissa width, excluding the hidden bit.
- Derived, not overridable: `W = 1+EXP_W+MAN_W`, `BIAS = 2^(EXP_W-1)-1`, `EMAX = 2^EXP_W-1`.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `st`  in  1  start; sampled only in IDLE.
- `ALUFunction`  in  4  opcode, captured with `st`.
- `DATA`  in  W  load operand.
- `REGA`, `REGB`  in  W  source operands.
- `REGOUT`  out  W  result register.
- `en`  out  1  one-cycle done pulse.
- `flag_io`  out  1  store strobe; high with `en` for STORE only.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `ovf`, `unf`, `zero`, `ill`  out  1 each  status of the last completed operation.

## Operation
- Opcodes: LOAD=0, MOV=1, ADD=2, NEG=3, STORE=4, MUL=6, MAX=7, SUB=8, CLR=9, MIN=10, ABS=11.
- Any other opcode (DIV=5 included): result 0, `ill`=1.
- FSM states: IDLE, ALIGN, CALC, NORM, DONE.
- IDLE with `st`=1: capture `ALUFunction`, `DATA`, `REGA`, `REGB`.
  - ADD/SUB/MUL go to ALIGN.
  - All other opcodes compute the result, load `REGOUT`/flags and go to DONE.
- ALIGN -> CALC -> NORM -> DONE -> IDLE, unconditional.
- Result and flags load on the edge entering DONE. They hold until the next such edge.
- Number format:
  - Exponent field 0 means zero; its mantissa is ignored and no denormals are produced.
  - No Inf/NaN: an exponent field of EMAX is an ordinary value.
- ADD/SUB:
  - SUB inverts B's sign, then the add path runs.
  - ALIGN computes `d = |ea-eb|` and right-shifts the smaller operand's `{1,man}` by `d`. Shifted-out bits are discarded; `d > MAN_W` contributes 0.
  - CALC does a same-sign add or a larger-minus-smaller subtract. Sign comes from the larger magnitude.
  - NORM: a carry gives right shift 1 and exponent +1; otherwise left shift to the leading one (full range), with the exponent decremented by the shift.
  - A zero mantissa gives +0.
- MUL:
  - Zero if either exponent field is 0.
  - Otherwise product of `{1,man}` terms is 2·(MAN_W+1) bits; exponent is `ea+eb-BIAS` in EXP_W+2-bit signed arithmetic; sign is the XOR of the operand signs.
  - NORM: top product bit set gives exponent +1. The mantissa is the MAN_W bits below the leading one, truncated.
- Range checks after normalisation, all paths:
  - Biased exponent > EMAX: result `{sign, all ones}`, `ovf`=1.
  - Biased exponent < 1: result +0, `unf`=1.
- Rounding is truncation everywhere.
- MAX/MIN: sign-magnitude compare; +0 equals -0. On equality the result is REGA.
- NEG flips bit W-1. ABS clears bit W-1. MOV and STORE pass REGA; LOAD passes DATA; CLR gives 0.
- `zero` = 1 when the result's exponent field is 0.
- All four flags clear at the start of each capture.

## Timing
- `st` sampled at edge N:
  - Arithmetic: `en` high during the cycle after edge N+3, low after edge N+4. Latency 4.
  - Other opcodes: `en` high after edge N, low after edge N+1. Latency 1.
- `en`, `flag_io` and `busy` are Moore outputs decoded from state. `busy`=0 only in IDLE.
- `st` while `busy` is ignored, not queued. `st` held high re-triggers on the first IDLE cycle.
- `rst` asserted mid-operation: immediately to IDLE, with `REGOUT`, `en`, `flag_io`, `busy` and all flags at 0. No `en` for the aborted op.
- Reset values: all outputs 0. State and captured operands are 0 / IDLE.

## Test plan
- Default params, ADD 0x3C00 + 0x4000:
  - `REGOUT`=0x4200, `en` one cycle, 4 edges after `st`, flags 0.
  - `busy` high for 4 cycles.
  - REGA/REGB changed after edge N leave the result unaffected.
- SUB 0x3C00 - 0x3C00 -> 0x0000, `zero`=1. SUB 0x4200 - 0x3C00 -> 0x4000.
- MUL:
  - 0x4000 × 0x3E00 -> 0x4200.
  - 0x7800 × 0x7800 -> 0x7FFF, `ovf`=1.
  - 0x0400 × 0x0400 -> 0x0000, `unf`=1.
- Single-cycle ops, each with `en` 1 edge after `st`; REGA=0xC000, REGB=0x3C00:
  - MAX -> 0x3C00; MIN -> 0xC000; ABS -> 0x4000.
  - STORE -> 0xC000 with `flag_io`=1 for the single `en` cycle.
  - Opcode 5 -> 0x0000, `ill`=1.
- Handshake:
  - `st` pulsed during ALIGN of an ADD is ignored.
  - `rst` in CALC: all outputs 0 at once; next `st` runs normally.
- EXP_W=8, MAN_W=23, ADD 0x3F800000 + 0x40000000 -> 0x40400000 with latency 4.
